// File: rtl/io_atr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : io_atr_sequencer
//  Purpose  : Auto TX/RX GPIO pattern sequencer with programmable guard delays,
//             configured over the serial register bus.
//  Option   : IO_ATR_SWITCH_COUNT_EN adds the tx_switch_count output/counter.
//  Revision : 1.0 - initial release
// ============================================================================
module io_atr_sequencer #(
  parameter logic [6:0]  BASE_ADDR = 7'd80,
  parameter int unsigned DELAY_W   = 12
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [6:0]  serial_addr,
  input  logic [31:0] serial_data,
  input  logic        serial_strobe,
  input  logic        tx_active,
  input  logic [15:0] gpio_in,
  output logic [15:0] atr_out,
  output logic [1:0]  atr_state
`ifdef IO_ATR_SWITCH_COUNT_EN
  ,
  output logic [15:0] tx_switch_count
`endif
);

  localparam logic [6:0]         C_ADDR_CTRL  = BASE_ADDR;
  localparam logic [6:0]         C_ADDR_MASK  = BASE_ADDR + 7'd1;
  localparam logic [6:0]         C_ADDR_TXVAL = BASE_ADDR + 7'd2;
  localparam logic [6:0]         C_ADDR_RXVAL = BASE_ADDR + 7'd3;
  localparam logic [6:0]         C_ADDR_DELAY = BASE_ADDR + 7'd4;
  localparam logic [DELAY_W-1:0] C_CNT_ONE    = {{(DELAY_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_RX       = 2'd0,
    ST_TX_DELAY = 2'd1,
    ST_TX       = 2'd2,
    ST_RX_DELAY = 2'd3
  } state_t;

  state_t               state_q;
  logic [DELAY_W-1:0]   cnt_q;

  logic                 enable_q,   enable_d;
  logic [15:0]          mask_q,     mask_d;
  logic [15:0]          txval_q,    txval_d;
  logic [15:0]          rxval_q,    rxval_d;
  logic [DELAY_W-1:0]   tx_delay_q, tx_delay_d;
  logic [DELAY_W-1:0]   rx_delay_q, rx_delay_d;

  logic                 w_wr_ctrl;
  logic                 w_wr_mask;
  logic                 w_wr_txval;
  logic                 w_wr_rxval;
  logic                 w_wr_delay;
  logic                 w_fsm_run;
  logic                 w_tx_entry;
  logic [15:0]          w_sel;
  logic                 w_unused_data;

  assign w_wr_ctrl  = serial_strobe && (serial_addr == C_ADDR_CTRL);
  assign w_wr_mask  = serial_strobe && (serial_addr == C_ADDR_MASK);
  assign w_wr_txval = serial_strobe && (serial_addr == C_ADDR_TXVAL);
  assign w_wr_rxval = serial_strobe && (serial_addr == C_ADDR_RXVAL);
  assign w_wr_delay = serial_strobe && (serial_addr == C_ADDR_DELAY);

  // Upper data bits are only partially decoded depending on DELAY_W.
  assign w_unused_data = ^serial_data;

  // A CTRL write clearing enable forces RX on the same edge as the write.
  assign w_fsm_run = enable_q && !(w_wr_ctrl && !serial_data[0]);

  // Entry into TX from RX or TX_DELAY; RX_DELAY re-entry is deliberately excluded.
  assign w_tx_entry = w_fsm_run && tx_active &&
                      (((state_q == ST_RX) && (tx_delay_q == '0)) ||
                       ((state_q == ST_TX_DELAY) && (cnt_q == '0)));

  always_comb begin
    enable_d   = enable_q;
    mask_d     = mask_q;
    txval_d    = txval_q;
    rxval_d    = rxval_q;
    tx_delay_d = tx_delay_q;
    rx_delay_d = rx_delay_q;
    if (w_wr_ctrl)  enable_d = serial_data[0];
    if (w_wr_mask)  mask_d   = serial_data[15:0];
    if (w_wr_txval) txval_d  = serial_data[15:0];
    if (w_wr_rxval) rxval_d  = serial_data[15:0];
    if (w_wr_delay) begin
      tx_delay_d = serial_data[DELAY_W-1:0];
      rx_delay_d = serial_data[16+DELAY_W-1:16];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      enable_q   <= 1'b0;
      mask_q     <= '0;
      txval_q    <= '0;
      rxval_q    <= '0;
      tx_delay_q <= '0;
      rx_delay_q <= '0;
    end else begin
      enable_q   <= enable_d;
      mask_q     <= mask_d;
      txval_q    <= txval_d;
      rxval_q    <= rxval_d;
      tx_delay_q <= tx_delay_d;
      rx_delay_q <= rx_delay_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_RX;
      cnt_q   <= '0;
    end else if (!w_fsm_run) begin
      state_q <= ST_RX;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_RX: begin
          if (tx_active) begin
            if (tx_delay_q == '0) begin
              state_q <= ST_TX;
            end else begin
              state_q <= ST_TX_DELAY;
              cnt_q   <= tx_delay_q - C_CNT_ONE;
            end
          end
        end
        ST_TX_DELAY: begin
          if (!tx_active) begin
            state_q <= ST_RX;
          end else if (cnt_q == '0) begin
            state_q <= ST_TX;
          end else begin
            cnt_q <= cnt_q - C_CNT_ONE;
          end
        end
        ST_TX: begin
          if (!tx_active) begin
            if (rx_delay_q == '0) begin
              state_q <= ST_RX;
            end else begin
              state_q <= ST_RX_DELAY;
              cnt_q   <= rx_delay_q - C_CNT_ONE;
            end
          end
        end
        ST_RX_DELAY: begin
          if (tx_active) begin
            state_q <= ST_TX;
          end else if (cnt_q == '0) begin
            state_q <= ST_RX;
          end else begin
            cnt_q <= cnt_q - C_CNT_ONE;
          end
        end
      endcase
    end
  end

`ifdef IO_ATR_SWITCH_COUNT_EN
  logic [15:0] count_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (w_wr_ctrl && serial_data[1]) begin
      count_q <= '0;
    end else if (w_tx_entry) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign tx_switch_count = count_q;
`else
  logic w_unused_entry;
  assign w_unused_entry = w_tx_entry;
`endif

  always_comb begin
    w_sel = ((state_q == ST_TX) || (state_q == ST_RX_DELAY)) ? txval_q : rxval_q;
    if (enable_q) begin
      atr_out = (gpio_in & ~mask_q) | (w_sel & mask_q);
    end else begin
      atr_out = gpio_in;
    end
  end

  assign atr_state = state_q;

endmodule
`default_nettype wire

// File: tb/tb_io_atr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_io_atr_sequencer
//  Purpose  : Self-checking bench for io_atr_sequencer (vector table + scoreboard).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_io_atr_sequencer;

  localparam logic [6:0]  A_NONE  = 7'd0;
  localparam logic [6:0]  A_CTRL  = 7'd80;
  localparam logic [6:0]  A_MASK  = 7'd81;
  localparam logic [6:0]  A_TXVAL = 7'd82;
  localparam logic [6:0]  A_RXVAL = 7'd83;
  localparam logic [6:0]  A_DELAY = 7'd84;
  localparam logic [1:0]  S_RX  = 2'd0;
  localparam logic [1:0]  S_TXD = 2'd1;
  localparam logic [1:0]  S_TX  = 2'd2;
  localparam logic [1:0]  S_RXD = 2'd3;
  localparam logic        WR = 1'b1;
  localparam logic        NW = 1'b0;
  localparam logic [15:0] P_RX = 16'h00C0;
  localparam logic [15:0] P_TX = 16'h0030;
  localparam logic [15:0] G0   = 16'h0000;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [6:0]  serial_addr = 7'd0;
  logic [31:0] serial_data = 32'd0;
  logic        serial_strobe = 1'b0;
  logic        tx_active = 1'b0;
  logic [15:0] gpio_in = 16'hA5A5;
  logic [15:0] atr_out;
  logic [1:0]  atr_state;
`ifdef IO_ATR_SWITCH_COUNT_EN
  logic [15:0] tx_switch_count;
`endif

  io_atr_sequencer dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .serial_addr   (serial_addr),
    .serial_data   (serial_data),
    .serial_strobe (serial_strobe),
    .tx_active     (tx_active),
    .gpio_in       (gpio_in),
    .atr_out       (atr_out),
    .atr_state     (atr_state)
`ifdef IO_ATR_SWITCH_COUNT_EN
    ,
    .tx_switch_count (tx_switch_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        wr;
    logic [6:0]  addr;
    logic [31:0] data;
    logic        txa;
    logic [15:0] gpio;
    logic [1:0]  exp_st;
    logic [15:0] exp_out;
  } vec_t;

  typedef struct packed {
    logic [1:0]  st;
    logic [15:0] out;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  function automatic vec_t mk(input logic wr, input logic [6:0] a, input logic [31:0] d,
                              input logic t, input logic [15:0] g,
                              input logic [1:0] s, input logic [15:0] o);
    vec_t v;
    v.wr = wr; v.addr = a; v.data = d; v.txa = t; v.gpio = g; v.exp_st = s; v.exp_out = o;
    return v;
  endfunction

  task automatic add(input logic wr, input logic [6:0] a, input logic [31:0] d,
                     input logic t, input logic [15:0] g,
                     input logic [1:0] s, input logic [15:0] o);
    vecs.push_back(mk(wr, a, d, t, g, s, o));
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge: drive, queue the expectation, then compare one edge later.
  task automatic step(input vec_t v, input string tag);
    exp_t e;
    serial_strobe = v.wr;
    serial_addr   = v.addr;
    serial_data   = v.data;
    tx_active     = v.txa;
    gpio_in       = v.gpio;
    e.st  = v.exp_st;
    e.out = v.exp_out;
    sb.push_back(e);
    @(posedge clock);
    @(negedge clock);
    serial_strobe = 1'b0;
    e = sb.pop_front();
    check({tag, ".state"}, 32'(atr_state), 32'(e.st));
    check({tag, ".out"},   32'(atr_out),   32'(e.out));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n_td;
    bit done;

    // Zero-delay setup and toggling
    add(NW, A_NONE,  32'd0,        1'b0, 16'hA5A5, S_RX, 16'hA5A5);
    add(WR, A_CTRL,  32'd1,        1'b0, G0, S_RX, G0);
    add(WR, A_MASK,  32'h00F0,     1'b0, G0, S_RX, G0);
    add(WR, A_TXVAL, 32'h0030,     1'b0, G0, S_RX, G0);
    add(WR, A_RXVAL, 32'h00C0,     1'b0, G0, S_RX, P_RX);
    add(WR, A_DELAY, 32'd0,        1'b0, G0, S_RX, P_RX);
    add(NW, A_NONE,  32'd0,        1'b1, G0, S_TX, P_TX);
    add(NW, A_NONE,  32'd0,        1'b1, G0, S_TX, P_TX);
    add(NW, A_NONE,  32'd0,        1'b0, G0, S_RX, P_RX);
    add(NW, A_NONE,  32'd0,        1'b0, 16'h1234, S_RX, 16'h12C4);
    // tx_delay=5, rx_delay=3
    add(WR, A_DELAY, 32'h0003_0005, 1'b0, G0, S_RX, P_RX);
    for (int i = 0; i < 5; i++) add(NW, A_NONE, 32'd0, 1'b1, G0, S_TXD, P_RX);
    add(NW, A_NONE,  32'd0,        1'b1, G0, S_TX, P_TX);
    for (int i = 0; i < 3; i++) add(NW, A_NONE, 32'd0, 1'b0, G0, S_RXD, P_TX);
    add(NW, A_NONE,  32'd0,        1'b0, G0, S_RX, P_RX);
    // tx_delay=10: abort after 4 cycles, then a full count with a DELAY write mid-count
    add(WR, A_DELAY, 32'h0003_000A, 1'b0, G0, S_RX, P_RX);
    for (int i = 0; i < 4; i++) add(NW, A_NONE, 32'd0, 1'b1, G0, S_TXD, P_RX);
    add(NW, A_NONE,  32'd0,        1'b0, G0, S_RX, P_RX);
    add(NW, A_NONE,  32'd0,        1'b1, G0, S_TXD, P_RX);
    add(NW, A_NONE,  32'd0,        1'b1, G0, S_TXD, P_RX);
    add(WR, A_DELAY, 32'h0003_0001, 1'b1, G0, S_TXD, P_RX);
    for (int i = 0; i < 7; i++) add(NW, A_NONE, 32'd0, 1'b1, G0, S_TXD, P_RX);
    add(NW, A_NONE,  32'd0,        1'b1, G0, S_TX, P_TX);
    // RX_DELAY re-entry to TX and mask writes mid-delay
    add(NW, A_NONE,  32'd0,        1'b0, G0, S_RXD, P_TX);
    add(NW, A_NONE,  32'd0,        1'b1, G0, S_TX, P_TX);
    add(NW, A_NONE,  32'd0,        1'b0, G0, S_RXD, P_TX);
    add(NW, A_NONE,  32'd0,        1'b0, G0, S_RXD, P_TX);
    add(WR, A_MASK,  32'h0F00,     1'b0, G0, S_RXD, G0);
    add(WR, A_MASK,  32'h00F0,     1'b0, G0, S_RX, P_RX);
    // New tx_delay=1 applies at the next load
    add(NW, A_NONE,  32'd0,        1'b1, G0, S_TXD, P_RX);
    add(NW, A_NONE,  32'd0,        1'b1, G0, S_TX, P_TX);
    add(NW, A_NONE,  32'd0,        1'b0, G0, S_RXD, P_TX);
    add(WR, A_DELAY, 32'd0,        1'b1, G0, S_TX, P_TX);
    add(NW, A_NONE,  32'd0,        1'b0, G0, S_RX, P_RX);
    // Disable during TX
    add(NW, A_NONE,  32'd0,        1'b1, G0, S_TX, P_TX);
    add(WR, A_CTRL,  32'd0,        1'b1, 16'h5A5A, S_RX, 16'h5A5A);
    add(NW, A_NONE,  32'd0,        1'b1, 16'h5A5A, S_RX, 16'h5A5A);
    add(WR, A_CTRL,  32'd1,        1'b1, G0, S_RX, P_RX);
    add(NW, A_NONE,  32'd0,        1'b1, G0, S_TX, P_TX);
    add(NW, A_NONE,  32'd0,        1'b0, G0, S_RX, P_RX);
    // Unmatched addresses ignored
    add(WR, 7'd85,   32'h0000_FFFF, 1'b0, G0, S_RX, P_RX);
    add(WR, 7'd79,   32'h0000_0000, 1'b0, G0, S_RX, P_RX);

    // Reset state
    #12;
    check("reset.state", 32'(atr_state), 32'(S_RX));
    check("reset.out",   32'(atr_out),   32'h0000_A5A5);
    @(negedge clock);
    reset_n = 1'b1;

    foreach (vecs[i]) step(vecs[i], $sformatf("v%0d", i));

    // Maximum tx_delay: 4095 cycles in TX_DELAY, then TX
    step(mk(WR, A_DELAY, 32'h0000_0FFF, 1'b0, G0, S_RX, P_RX), "maxd.load");
    tx_active = 1'b1;
    n_td = 0;
    done = 1'b0;
    for (int c = 0; c < 5000 && !done; c++) begin
      @(posedge clock);
      @(negedge clock);
      if (atr_state == S_TXD) n_td++;
      else done = 1'b1;
    end
    check("maxd.cycles", n_td, 32'd4095);
    check("maxd.state", 32'(atr_state), 32'(S_TX));
    step(mk(NW, A_NONE, 32'd0, 1'b0, G0, S_RX, P_RX), "maxd.exit");

    // Asynchronous reset mid-RX_DELAY
    step(mk(WR, A_DELAY, 32'h0003_0000, 1'b0, G0, S_RX, P_RX), "ar.cfg");
    step(mk(NW, A_NONE, 32'd0, 1'b1, G0, S_TX, P_TX), "ar.tx");
    step(mk(NW, A_NONE, 32'd0, 1'b0, G0, S_RXD, P_TX), "ar.rxd");
    #2 reset_n = 1'b0;
    #1;
    check("ar.state", 32'(atr_state), 32'(S_RX));
    check("ar.out",   32'(atr_out),   32'h0);
`ifdef IO_ATR_SWITCH_COUNT_EN
    check("ar.count", 32'(tx_switch_count), 32'h0);
`endif
    @(negedge clock);
    reset_n = 1'b1;
    step(mk(WR, A_CTRL, 32'd1, 1'b0, 16'hFFFF, S_RX, 16'hFFFF), "ar.mask0");
    step(mk(WR, A_MASK, 32'h000F, 1'b0, 16'hFFFF, S_RX, 16'hFFF0), "ar.rxval0");

`ifdef IO_ATR_SWITCH_COUNT_EN
    // TX entry counter: RX_DELAY re-entry must not count
    step(mk(WR, A_DELAY, 32'h0002_0002, 1'b0, G0, S_RX, G0), "cnt.cfg");
    check("cnt.init", 32'(tx_switch_count), 32'h0);
    for (int b = 0; b < 3; b++) begin
      step(mk(NW, A_NONE, 32'd0, 1'b1, G0, S_TXD, G0), $sformatf("cnt.b%0d.td0", b));
      step(mk(NW, A_NONE, 32'd0, 1'b1, G0, S_TXD, G0), $sformatf("cnt.b%0d.td1", b));
      step(mk(NW, A_NONE, 32'd0, 1'b1, G0, S_TX,  G0), $sformatf("cnt.b%0d.tx", b));
      step(mk(NW, A_NONE, 32'd0, 1'b0, G0, S_RXD, G0), $sformatf("cnt.b%0d.rxd", b));
      step(mk(NW, A_NONE, 32'd0, 1'b1, G0, S_TX,  G0), $sformatf("cnt.b%0d.re", b));
      step(mk(NW, A_NONE, 32'd0, 1'b0, G0, S_RXD, G0), $sformatf("cnt.b%0d.rd0", b));
      step(mk(NW, A_NONE, 32'd0, 1'b0, G0, S_RXD, G0), $sformatf("cnt.b%0d.rd1", b));
      step(mk(NW, A_NONE, 32'd0, 1'b0, G0, S_RX,  G0), $sformatf("cnt.b%0d.rx", b));
      check($sformatf("cnt.after%0d", b), 32'(tx_switch_count), 32'(b + 1));
    end
    step(mk(WR, A_CTRL, 32'h3, 1'b0, G0, S_RX, G0), "cnt.clr");
    check("cnt.cleared", 32'(tx_switch_count), 32'h0);
    step(mk(NW, A_NONE, 32'd0, 1'b1, G0, S_TXD, G0), "cnt.still_en");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
